serial_receiver: RTL
====================

SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning CLK cycles per serial bit (even, minimum 4).
REQ-002 SHALL have port CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port IN_SERIAL_RX  input  1  asynchronous serial line, idle high, 8N1 frame, LSB first.
REQ-005 SHALL have port IN_READ  input  1  consumer acknowledge; clears OUT_VALID.
REQ-006 SHALL have port OUT_DATA  output  8  last correctly received byte.
REQ-007 SHALL have port OUT_VALID  output  1  OUT_DATA holds an unread byte.
REQ-008 SHALL have port OUT_FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port OUT_OVERRUN  output  1  sticky: byte overwritten while unread.
REQ-010 SHALL have port OUT_BUSY  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass IN_SERIAL_RX through a 2-flop synchronizer; "rx" below means the synchronizer output.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE with a bit-timing counter and a 3-bit bit index.
REQ-013 IDLE: rx==0 SHALL move to START with counter cleared.
REQ-014 START: at counter==CLKS_PER_BIT/2-1, rx==0 SHALL move to DATA with counter cleared; rx==1 SHALL return to IDLE (glitch rejection, no outputs change).
REQ-015 DATA: at each counter==CLKS_PER_BIT-1 SHALL shift rx into bit[index], index 0..7; after index 7 SHALL move to STOP.
REQ-016 STOP: at counter==CLKS_PER_BIT-1, rx==1 SHALL load OUT_DATA and set OUT_VALID on the next edge, then go to IDLE.
REQ-017 STOP: rx==0 SHALL pulse OUT_FRAME_ERR one cycle, leave OUT_DATA/OUT_VALID unchanged, and go to WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL remain until rx==1, then go to IDLE (break condition never produces bytes).
REQ-019 IN_READ while OUT_VALID SHALL clear OUT_VALID and OUT_OVERRUN on the next edge; IN_READ while not valid SHALL have no effect.
REQ-020 Byte completion with OUT_VALID=1 and no IN_READ that cycle SHALL overwrite OUT_DATA, keep OUT_VALID=1, set OUT_OVERRUN.
REQ-021 Byte completion coincident with IN_READ SHALL load new data, keep OUT_VALID=1, not set OUT_OVERRUN.
REQ-022 Latency: OUT_VALID SHALL rise exactly one CLK after the stop-bit sample edge.

Reset
REQ-023 RESET_N low SHALL immediately force state IDLE, counters 0, synchronizer flops 1, OUT_DATA=0x00, OUT_VALID=0, OUT_FRAME_ERR=0, OUT_OVERRUN=0, OUT_BUSY=0.
REQ-024 Reset deasserted mid-frame SHALL resume in IDLE and SHALL not emit a byte from the partial frame.

Configuration
REQ-025 Macro SERIAL_RX_PARITY_EN defined SHALL insert state PARITY between DATA and STOP, sampling one even-parity bit at counter==CLKS_PER_BIT-1.
REQ-026 With SERIAL_RX_PARITY_EN, port OUT_PARITY_ERR (output, 1) SHALL pulse one cycle at the stop sample if parity mismatched, and that byte SHALL be discarded (OUT_VALID unchanged).
REQ-027 Without SERIAL_RX_PARITY_EN, frame SHALL be 8N1 and OUT_PARITY_ERR SHALL not exist.

Verification
REQ-028 CLKS_PER_BIT=16, send 0xA5 8N1 -> OUT_DATA=0xA5, OUT_VALID=1 one CLK after stop sample, OUT_FRAME_ERR=0.
REQ-029 Low glitch of 4 CLK on idle line -> returns to IDLE, OUT_VALID stays 0, OUT_BUSY low again within 8 CLK.
REQ-030 Send 0x3C with stop bit 0, hold line low 40 bit times -> one OUT_FRAME_ERR pulse, no OUT_VALID, next 0x55 received correctly.
REQ-031 Send 0x11 then 0x22 without IN_READ -> OUT_DATA=0x22, OUT_VALID=1, OUT_OVERRUN=1; IN_READ -> both clear next edge.
REQ-032 RESET_N low during bit 3 of 0xFF, released, then send 0x81 -> only 0x81 reported.
REQ-033 SERIAL_RX_PARITY_EN: send 0x07 with parity 1 -> valid 0x07; parity 0 -> OUT_PARITY_ERR pulse, no OUT_VALID.

Source files
------------

// File: rtl/serial_receiver.sv
// serial_receiver
//   Asynchronous serial (UART-style) receiver, idle-high line, LSB first,
//   CLKS_PER_BIT system clocks per bit (even, >= 4). Mid-bit sampling after a
//   half-bit start confirmation.
//
//   Optional feature: define SERIAL_RX_PARITY_EN to receive 8E1 frames
//   (one even-parity bit between data and stop); bad-parity bytes are dropped
//   and reported on OUT_PARITY_ERR. Without the macro the frame is 8N1.
//
// Ports
//   CLK            in   system clock, rising edge
//   RESET_N        in   asynchronous active-low reset
//   IN_SERIAL_RX   in   asynchronous serial line (synchronized internally)
//   IN_READ        in   consumer acknowledge, clears OUT_VALID/OUT_OVERRUN
//   OUT_DATA       out  last correctly received byte
//   OUT_VALID      out  OUT_DATA holds an unread byte
//   OUT_FRAME_ERR  out  one-cycle pulse: stop bit sampled low
//   OUT_OVERRUN    out  sticky: unread byte was overwritten
//   OUT_BUSY       out  receiver not idle
//   OUT_PARITY_ERR out  (parity build only) one-cycle pulse: parity mismatch
module serial_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       IN_SERIAL_RX,
  input  logic       IN_READ,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  output logic       OUT_FRAME_ERR,
  output logic       OUT_OVERRUN,
  output logic       OUT_BUSY
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic       OUT_PARITY_ERR
`endif
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t CNT_HALF = cnt_t'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       load_q, load_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
`ifdef SERIAL_RX_PARITY_EN
  logic       par_q, par_d;
  logic       parity_err_q, parity_err_d;
`endif

  logic rx;
  assign rx = sync2_q;

  always_comb begin
    sync1_d     = IN_SERIAL_RX;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q + cnt_t'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    load_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx) state_d = START;
      end
      START: begin
        // Half-bit confirmation rejects short low glitches.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx) begin
            state_d = IDLE;
`ifdef SERIAL_RX_PARITY_EN
            if ((^shift_q) == par_q) load_d = 1'b1;
            else                     parity_err_d = 1'b1;
`else
            load_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output holding register. A load one cycle after the stop sample wins over
  // a coincident read, so read+load leaves a fresh valid byte without overrun.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && IN_READ) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (load_q) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !IN_READ) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    OUT_DATA      = data_q;
    OUT_VALID     = valid_q;
    OUT_FRAME_ERR = frame_err_q;
    OUT_OVERRUN   = overrun_q;
    OUT_BUSY      = (state_q != IDLE);
  end
`ifdef SERIAL_RX_PARITY_EN
  assign OUT_PARITY_ERR = parity_err_q;
`endif

endmodule
